// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
// Shares one external binary-to-BCD converter among NREQ clients using
// round-robin arbitration and valid/ready handshakes on both sides.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate; accept the round-robin winner's operand
// CONV  | operand held on conv_bin, waiting CONV_LAT cycles for result
// RESP  | result offered to the granted client until it takes it
module bcd_conv_arbiter #(
  parameter int NREQ     = 4,
  parameter int BIN_W    = 20,
  parameter int BCD_W    = 32,
  parameter int CONV_LAT = 1,
  parameter int GID_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*BIN_W-1:0]  req_bin,
  output logic [NREQ-1:0]        req_ready,
  output logic [BIN_W-1:0]       conv_bin,
  input  logic [BCD_W-1:0]       conv_bcd,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [BCD_W-1:0]       rsp_bcd,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic                   busy,
  output logic [GID_W-1:0]       grant_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter only needs to hold CONV_LAT-1; keep at least one bit.
  localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  // Per-client vectors are widened to 2**GID_W entries so they can be
  // indexed directly by a GID_W-bit client number.
  localparam int SLOTS = 1 << GID_W;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] conv_bin_q, conv_bin_d;
  logic [BCD_W-1:0] rsp_bcd_q, rsp_bcd_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [GID_W-1:0] last_q, last_d;

  logic [SLOTS-1:0] valid_pad;
  logic [SLOTS-1:0] ready_pad;
  logic [BIN_W-1:0] bin_arr [SLOTS];

  logic             win_found;
  logic [GID_W-1:0] win_idx;
  logic [GID_W:0]   cand;

  assign valid_pad = SLOTS'(req_valid);
  assign ready_pad = SLOTS'(rsp_ready);

  // Unpack client operands; unused slots read as zero.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      bin_arr[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      bin_arr[i] = req_bin[i*BIN_W +: BIN_W];
    end
  end

  // Round-robin search starting just after the last served client.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + (GID_W+1)'(k);
      if (cand >= (GID_W+1)'(NREQ)) begin
        cand = cand - (GID_W+1)'(NREQ);
      end
      if (!win_found && valid_pad[cand[GID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GID_W-1:0];
      end
    end
  end

  // Next-state and datapath update for the IDLE/CONV/RESP sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    conv_bin_d = conv_bin_q;
    rsp_bcd_d  = rsp_bcd_q;
    grant_d    = grant_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE: begin
        // A winner always sees req_ready, so finding one means a transfer.
        if (win_found) begin
          conv_bin_d = bin_arr[win_idx];
          grant_d    = win_idx;
          cnt_d      = CNT_W'(CONV_LAT - 1);
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == '0) begin
          rsp_bcd_d = conv_bcd;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (ready_pad[grant_q]) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from state and the current winner.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == S_IDLE && win_found) begin
      req_ready = NREQ'(1) << win_idx;
    end
    if (state_q == S_RESP) begin
      rsp_valid = NREQ'(1) << grant_q;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign conv_bin = conv_bin_q;
  assign rsp_bcd  = rsp_bcd_q;
  assign grant_id = grant_q;

  // State registers; reset drops any job in flight and gives client 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      conv_bin_q <= '0;
      rsp_bcd_q  <= '0;
      grant_q    <= '0;
      last_q     <= GID_W'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      conv_bin_q <= conv_bin_d;
      rsp_bcd_q  <= rsp_bcd_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Testbench for bcd_conv_arbiter: cycle-level reference model of the
// arbitration/handshake rules plus an arithmetic BCD converter model.
module tb_bcd_conv_arbiter;

  localparam int NREQ  = 4;
  localparam int BIN_W = 20;
  localparam int BCD_W = 32;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance, CONV_LAT = 1, combinational converter
  logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*BIN_W-1:0] req_bin;
  logic [BIN_W-1:0]      conv_bin;
  logic [BCD_W-1:0]      conv_bcd, rsp_bcd;
  logic                  busy;
  logic [2:0]            grant_id;

  // second instance, CONV_LAT = 3, two-register converter
  logic [NREQ-1:0]       v3, rdy3, rv3, rr3;
  logic [NREQ*BIN_W-1:0] b3;
  logic [BIN_W-1:0]      cb3;
  logic [BCD_W-1:0]      cbcd3, rbcd3, pipe1, pipe2;
  logic                  busy3;
  logic [2:0]            gid3;

  logic [BIN_W-1:0] cl_bin [NREQ];
  logic [NREQ-1:0]  pend;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [31:0] to_bcd(input logic [19:0] b);
    int v;
    logic [31:0] r;
    v = int'(b);
    r = '0;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  assign conv_bcd = to_bcd(conv_bin);
  always @(posedge clk) begin
    pipe1 <= to_bcd(cb3);
    pipe2 <= pipe1;
  end
  assign cbcd3 = pipe2;

  always_comb begin
    req_bin = '0;
    for (int i = 0; i < NREQ; i++) req_bin[i*BIN_W +: BIN_W] = cl_bin[i];
  end
  assign req_valid = pend;

  bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W), .BCD_W(BCD_W), .CONV_LAT(LAT), .GID_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bin(req_bin), .req_ready(req_ready),
    .conv_bin(conv_bin), .conv_bcd(conv_bcd), .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd),
    .rsp_ready(rsp_ready), .busy(busy), .grant_id(grant_id));

  bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W), .BCD_W(BCD_W), .CONV_LAT(3), .GID_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_bin(b3), .req_ready(rdy3),
    .conv_bin(cb3), .conv_bcd(cbcd3), .rsp_valid(rv3), .rsp_bcd(rbcd3),
    .rsp_ready(rr3), .busy(busy3), .grant_id(gid3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: phase 0 = idle, 1 = converting, 2 = response offered
  int m_phase, m_left, m_last, m_gid, acc;
  logic [19:0] m_bin;
  logic [31:0] m_bcd;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_last = NREQ - 1; m_gid = 0;
    m_bin = '0; m_bcd = '0; acc = -1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // compare outputs for the current cycle, predict the edge, then advance
  task automatic step();
    int w;
    logic [NREQ-1:0] e_rr, e_rv;
    #1;
    w = -1; e_rr = '0; e_rv = '0;
    if (m_phase == 0) begin
      w = pick(req_valid, m_last);
      if (w >= 0) e_rr = NREQ'(1) << w;
    end
    if (m_phase == 2) e_rv = NREQ'(1) << m_gid;
    chk("req_ready", req_ready, e_rr);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("busy", busy, m_phase != 0);
    chk("grant_id", grant_id, m_gid);
    chk("conv_bin", conv_bin, m_bin);
    chk("rsp_bcd", rsp_bcd, m_bcd);
    acc = -1;
    case (m_phase)
      0: if (w >= 0) begin
           m_bin = cl_bin[w]; m_gid = w; m_left = LAT; m_phase = 1; acc = w;
         end
      1: begin
           m_left--;
           if (m_left == 0) begin m_bcd = to_bcd(m_bin); m_phase = 2; end
         end
      default: if (rsp_ready[m_gid]) begin m_last = m_gid; m_phase = 0; end
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [19:0] rand_bin();
    case ($urandom % 4)
      0: return 20'd0;
      1: return 20'd1048575;
      2: return 20'd99999;
      default: return 20'($urandom % 1048576);
    endcase
  endfunction

  task automatic drain();
    pend = '0; rsp_ready = '1;
    repeat (LAT + 3) step();
  endtask

  task automatic one_job(input int c, input logic [19:0] b, input logic [31:0] e);
    pend = '0; rsp_ready = '1;
    pend[c] = 1'b1; cl_bin[c] = b;
    step();
    pend[c] = 1'b0;
    repeat (LAT) step();
    #1;
    chk("job_valid", rsp_valid, NREQ'(1) << c);
    chk("job_bcd", rsp_bcd, e);
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_bcd"}, rsp_bcd, 0);
    chk({tag, "_conv_bin"}, conv_bin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  initial begin
    logic [NREQ-1:0] seen [$];
    logic [NREQ-1:0] exp_order [6];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    rst_n = 1'b0; pend = '0; rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) cl_bin[i] = '0;
    v3 = '0; b3 = '0; rr3 = '1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_busy3", busy3, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // CONV_LAT=3 instance: response four cycles after the accept cycle
    v3 = 4'b0010; b3[1*BIN_W +: BIN_W] = 20'd54321;
    #1;
    chk("lat3_req_ready", rdy3, 4'b0010);
    @(posedge clk); @(negedge clk);
    v3 = '0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("lat3_conv_bin", cb3, 20'd54321);
      chk("lat3_no_rsp", rv3, 0);
      @(posedge clk); @(negedge clk);
    end
    #1;
    chk("lat3_rsp_valid", rv3, 4'b0010);
    chk("lat3_rsp_bcd", rbcd3, 32'h00054321);
    @(posedge clk); @(negedge clk);
    #1;
    chk("lat3_done", busy3, 0);

    // all clients valid continuously: strict rotation, one job per 3 cycles
    rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b1; cl_bin[i] = rand_bin(); end
    for (int c = 0; c < 18; c++) begin
      #1;
      if (req_ready != 0) seen.push_back(req_ready);
      step();
      if (acc >= 0) cl_bin[acc] = rand_bin();
    end
    chk("rr_count", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) chk("rr_order", seen[i], exp_order[i]);
    drain();

    // single jobs incl. boundary operands
    one_job(0, 20'd12345, 32'h00012345);
    one_job(1, 20'd0, 32'h00000000);
    one_job(2, 20'd1048575, 32'h01048575);
    one_job(3, 20'd99999, 32'h00099999);
    drain();

    // stall client 2 in RESP while client 0 waits
    pend = 4'b0100; cl_bin[2] = 20'd31415;
    step();
    pend = 4'b0001; cl_bin[0] = 20'd27182; rsp_ready = 4'b1011;
    repeat (LAT) step();
    repeat (10) begin
      #1;
      chk("stall_valid", rsp_valid, 4'b0100);
      chk("stall_bcd", rsp_bcd, 32'h00031415);
      chk("stall_ready", req_ready, 0);
      step();
    end
    rsp_ready = '1;
    step();
    #1;
    chk("after_stall_grant", req_ready, 4'b0001);
    step();
    pend = '0;
    drain();

    // randomized traffic with withdrawals and response back-pressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom % 2 == 0) begin pend[i] = 1'b1; cl_bin[i] = rand_bin(); end
        end else if ($urandom % 20 == 0) begin
          pend[i] = 1'b0;
        end
        rsp_ready[i] = ($urandom % 10) < 7;
      end
      step();
      if (acc >= 0) pend[acc] = 1'b0;
    end
    drain();

    // reset during CONV discards the job and restores client 0 priority
    pend = 4'b1000; cl_bin[3] = 20'd777;
    step();
    pend = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    pend = '1;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    step();
    pend = '0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
